// File: rtl/gpu_pkg.sv
// Shared types and constants for the rectangle-fill engine.
// FSM state encoding, framebuffer defaults and byte-lane mask widths.
package gpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int FB_WIDTH_DEF  = 400;
   localparam int FB_HEIGHT_DEF = 300;

   localparam int LANE_BITS = 2;
   localparam int LANES     = 4;

endpackage

// File: rtl/rect_fill_lane_mask.sv
// Byte-lane write mask: enables every lane from start_lane_i through end_lane_i inclusive.
module rect_fill_lane_mask
   import gpu_pkg::*;
(
   input  logic [LANE_BITS-1:0] start_lane_i,
   input  logic [LANE_BITS-1:0] end_lane_i,
   output logic [LANES-1:0]     mask_o
);

   always_comb begin
      mask_o = '0;
      for (int i = 0; i < LANES; i++) begin
         if ((LANE_BITS'(i) >= start_lane_i) && (LANE_BITS'(i) <= end_lane_i)) begin
            mask_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: writes one framebuffer word per cycle, one byte per pixel.
// Optional macro RECT_FILL_CLIP_EN clips to the framebuffer instead of rejecting.
module rect_fill
   import gpu_pkg::*;
#(
   parameter int FB_WIDTH       = FB_WIDTH_DEF,
   parameter int FB_HEIGHT      = FB_HEIGHT_DEF,
   parameter int COORD_BITS     = 10,
   parameter int BRAM_ADDR_BITS = 32,
   parameter int BRAM_DATA_BITS = 32
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic [COORD_BITS-1:0]       cmd_x_i,
   input  logic [COORD_BITS-1:0]       cmd_y_i,
   input  logic [COORD_BITS-1:0]       cmd_w_i,
   input  logic [COORD_BITS-1:0]       cmd_h_i,
   input  logic [7:0]                  cmd_color_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o,
   output logic                        bram_clk_o,
   output logic                        bram_rst_o,
   output logic                        bram_en_o,
   output logic [BRAM_ADDR_BITS-1:0]   bram_addr_o,
   output logic [BRAM_DATA_BITS-1:0]   bram_din_o,
   input  logic [BRAM_DATA_BITS-1:0]   bram_dout_i,
   output logic [BRAM_DATA_BITS/8-1:0] bram_we_o
);

   localparam int CW1 = COORD_BITS + 1;
   localparam int AW  = BRAM_ADDR_BITS;
   localparam int BW  = BRAM_DATA_BITS / 8;
   localparam logic [CW1-1:0] FB_W_C = CW1'(FB_WIDTH);
   localparam logic [CW1-1:0] FB_H_C = CW1'(FB_HEIGHT);

   // Handshake: a command transfers on a rising edge where cmd_valid_i and
   // cmd_ready_o are both high; ready is high only in IDLE.
   state_t                state_q, state_d;
   logic [COORD_BITS-1:0] cx_q, cx_d, cy_q, cy_d, cw_q, cw_d, ch_q, ch_d;
   logic [7:0]            color_q, color_d;
   logic [CW1-1:0]        x_q, x_d, y_q, y_d, x_end_q, x_end_d, y_end_q, y_end_d;
   logic [AW-1:0]         row_base_q, row_base_d;
   logic                  err_q, err_d;

   logic [CW1-1:0]        x_end_raw, y_end_raw, x_end_s, y_end_s;
   logic                  setup_err, setup_empty;
   logic [AW-1:0]         pix_addr, row_last;
   logic [LANE_BITS-1:0]  start_lane, end_lane;
   logic [LANES-1:0]      lane_mask;
   logic [CW1-1:0]        x_adv, y_inc;
   logic                  row_done, last_row, in_fill;
   logic                  dout_unused;

   assign dout_unused = ^bram_dout_i;

   assign x_end_raw = {1'b0, cx_q} + {1'b0, cw_q};
   assign y_end_raw = {1'b0, cy_q} + {1'b0, ch_q};

`ifdef RECT_FILL_CLIP_EN
   assign x_end_s   = (x_end_raw > FB_W_C) ? FB_W_C : x_end_raw;
   assign y_end_s   = (y_end_raw > FB_H_C) ? FB_H_C : y_end_raw;
   assign setup_err = 1'b0;
`else
   assign x_end_s   = x_end_raw;
   assign y_end_s   = y_end_raw;
   assign setup_err = (x_end_raw > FB_W_C) || (y_end_raw > FB_H_C);
`endif

   // Clipped origin beyond the edge collapses to an empty area here too.
   assign setup_empty = setup_err || (x_end_s <= {1'b0, cx_q}) || (y_end_s <= {1'b0, cy_q});

   assign pix_addr   = row_base_q + AW'(x_q);
   assign row_last   = row_base_q + AW'(x_end_q) - AW'(1);
   assign start_lane = pix_addr[LANE_BITS-1:0];
   assign end_lane   = (pix_addr[AW-1:LANE_BITS] == row_last[AW-1:LANE_BITS]) ?
                       row_last[LANE_BITS-1:0] : LANE_BITS'(LANES - 1);
   assign x_adv      = x_q + CW1'(3'd4 - {1'b0, start_lane});
   assign y_inc      = y_q + CW1'(1);
   assign row_done   = (x_adv >= x_end_q);
   assign last_row   = (y_inc >= y_end_q);

   rect_fill_lane_mask u_lane_mask (
      .start_lane_i (start_lane),
      .end_lane_i   (end_lane),
      .mask_o       (lane_mask)
   );

   always_comb begin
      state_d    = state_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      cw_d       = cw_q;
      ch_d       = ch_q;
      color_d    = color_q;
      x_d        = x_q;
      y_d        = y_q;
      x_end_d    = x_end_q;
      y_end_d    = y_end_q;
      row_base_d = row_base_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               cx_d    = cmd_x_i;
               cy_d    = cmd_y_i;
               cw_d    = cmd_w_i;
               ch_d    = cmd_h_i;
               color_d = cmd_color_i;
               state_d = SETUP;
            end
         end
         SETUP: begin
            x_end_d    = x_end_s;
            y_end_d    = y_end_s;
            x_d        = {1'b0, cx_q};
            y_d        = {1'b0, cy_q};
            row_base_d = AW'(cy_q) * AW'(FB_WIDTH);
            err_d      = setup_err;
            state_d    = setup_empty ? DONE : FILL;
         end
         FILL: begin
            if (row_done) begin
               x_d        = {1'b0, cx_q};
               y_d        = y_inc;
               row_base_d = row_base_q + AW'(FB_WIDTH);
               if (last_row) begin
                  state_d = DONE;
               end
            end else begin
               x_d = x_adv;
            end
         end
         DONE: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         cx_q       <= '0;
         cy_q       <= '0;
         cw_q       <= '0;
         ch_q       <= '0;
         color_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         x_end_q    <= '0;
         y_end_q    <= '0;
         row_base_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         cw_q       <= cw_d;
         ch_q       <= ch_d;
         color_q    <= color_d;
         x_q        <= x_d;
         y_q        <= y_d;
         x_end_q    <= x_end_d;
         y_end_q    <= y_end_d;
         row_base_q <= row_base_d;
         err_q      <= err_d;
      end
   end

   assign in_fill     = (state_q == FILL);
   assign cmd_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign err_o       = (state_q == DONE) && err_q;

   assign bram_clk_o  = clk_i;
   assign bram_rst_o  = ~reset_ni;
   assign bram_we_o   = in_fill ? BW'(lane_mask) : '0;
   assign bram_en_o   = |bram_we_o;
   assign bram_addr_o = in_fill ? {pix_addr[AW-1:LANE_BITS], {LANE_BITS{1'b0}}} : '0;
   assign bram_din_o  = in_fill ? {BW{color_q}} : '0;

endmodule

// File: tb/tb_rect_fill.sv
// Directed self-checking bench for rect_fill; expected BRAM writes are queued
// as {addr, we, din} and matched in order, with latency checked per cycle.
module tb_rect_fill;

   localparam int W = 68;

   logic        clk = 1'b0;
   logic        reset_ni;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
   logic [7:0]  cmd_color;
   logic        busy, done, err;
   logic        bram_clk, bram_rst, bram_en;
   logic [31:0] bram_addr, bram_din;
   logic [31:0] bram_dout = 32'hDEAD_BEEF;
   logic [3:0]  bram_we;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   rect_fill dut (
      .clk_i       (clk),
      .reset_ni    (reset_ni),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_x_i     (cmd_x),
      .cmd_y_i     (cmd_y),
      .cmd_w_i     (cmd_w),
      .cmd_h_i     (cmd_h),
      .cmd_color_i (cmd_color),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err),
      .bram_clk_o  (bram_clk),
      .bram_rst_o  (bram_rst),
      .bram_en_o   (bram_en),
      .bram_addr_o (bram_addr),
      .bram_din_o  (bram_din),
      .bram_dout_i (bram_dout),
      .bram_we_o   (bram_we)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] wr(input logic [31:0] a, input logic [3:0] we, input logic [7:0] c);
      return {a, we, {4{c}}};
   endfunction

   task automatic drive_cmd(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                            input logic [9:0] h, input logic [7:0] c);
      cmd_valid = 1'b1;
      cmd_x     = x;
      cmd_y     = y;
      cmd_w     = w;
      cmd_h     = h;
      cmd_color = c;
   endtask

   task automatic scramble_cmd();
      cmd_x     = 10'($urandom_range(0, 1023));
      cmd_y     = 10'($urandom_range(0, 1023));
      cmd_w     = 10'($urandom_range(0, 1023));
      cmd_h     = 10'($urandom_range(0, 1023));
      cmd_color = 8'($urandom_range(0, 255));
   endtask

   // Issue one command at a negedge (cycle 0) and follow it to completion.
   task automatic run_cmd(input string tag, input logic [9:0] x, input logic [9:0] y,
                          input logic [9:0] w, input logic [9:0] h, input logic [7:0] c,
                          input int done_cyc, input logic exp_err);
      int   nw;
      logic seen_done;
      drive_cmd(x, y, w, h, c);
      check({tag, " ready"}, W'(cmd_ready), W'(1));
      @(negedge clk);
      cmd_valid = 1'b0;
      scramble_cmd();
      check({tag, " busy"}, W'(busy), W'(1));
      nw        = 0;
      seen_done = 1'b0;
      for (int cyc = 1; cyc < 300 && !seen_done; cyc++) begin
         if (cyc > 1) @(negedge clk);
         check({tag, " en_vs_we"}, W'(bram_en), W'(|bram_we));
         check({tag, " err"}, W'(err), W'(done & exp_err));
         if (bram_en) begin
            if (exp_q.size() == 0) begin
               check({tag, " extra_write"}, W'(bram_en), W'(0));
            end else begin
               check($sformatf("%s write%0d", tag, nw), {bram_addr, bram_we, bram_din}, exp_q.pop_front());
               check($sformatf("%s write%0d_cycle", tag, nw), W'(cyc), W'(2 + nw));
            end
            nw++;
         end
         if (done) begin
            seen_done = 1'b1;
            check({tag, " done_cycle"}, W'(cyc), W'(done_cyc));
         end
      end
      check({tag, " done_seen"}, W'(seen_done), W'(1));
      check({tag, " writes_left"}, W'(exp_q.size()), W'(0));
      exp_q.delete();
      @(negedge clk);
      check({tag, " idle_ready"}, W'(cmd_ready), W'(1));
      check({tag, " idle_busy"}, W'(busy), W'(0));
   endtask

   initial begin
      // Reset
      reset_ni  = 1'b0;
      cmd_valid = 1'b0;
      scramble_cmd();
      repeat (2) @(negedge clk);
      check("rst ready", W'(cmd_ready), W'(1));
      check("rst busy", W'(busy), W'(0));
      check("rst done", W'(done), W'(0));
      check("rst err", W'(err), W'(0));
      check("rst bram", {bram_en, bram_we, bram_addr, bram_din}, W'(0));
      check("rst bram_rst", W'(bram_rst), W'(1));
      check("bram_clk", W'(bram_clk), W'(clk));
      reset_ni = 1'b1;
      @(negedge clk);
      check("bram_rst released", W'(bram_rst), W'(0));

      // 8x1 at origin: two full words, done in cycle 4
      exp_q.push_back(wr(32'd0, 4'b1111, 8'h5A));
      exp_q.push_back(wr(32'd4, 4'b1111, 8'h5A));
      run_cmd("fill8x1", 10'd0, 10'd0, 10'd8, 10'd1, 8'h5A, 4, 1'b0);

      // 6x2 at (3,2): rows at 800 and 1200, partial edge words
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(wr(32'(800 + 400 * r), 4'b1000, 8'hC3));
         exp_q.push_back(wr(32'(804 + 400 * r), 4'b1111, 8'hC3));
         exp_q.push_back(wr(32'(808 + 400 * r), 4'b0001, 8'hC3));
      end
      run_cmd("fill6x2", 10'd3, 10'd2, 10'd6, 10'd2, 8'hC3, 8, 1'b0);

      // Empty areas
      run_cmd("w0", 10'd5, 10'd5, 10'd0, 10'd5, 8'h11, 2, 1'b0);
      run_cmd("h0", 10'd7, 10'd9, 10'd3, 10'd0, 8'h22, 2, 1'b0);

      // Single pixel: byte 405 -> word 404 lane 1
      exp_q.push_back(wr(32'd404, 4'b0010, 8'h99));
      run_cmd("pixel", 10'd5, 10'd1, 10'd1, 10'd1, 8'h99, 3, 1'b0);

      // Exactly touching the bottom-right corner: byte 119998 -> word 119996 lanes 2..3
      exp_q.push_back(wr(32'd119996, 4'b1100, 8'h3C));
      run_cmd("corner", 10'd398, 10'd299, 10'd2, 10'd1, 8'h3C, 3, 1'b0);

`ifdef RECT_FILL_CLIP_EN
      // Clipped to (396..399, 299): byte 299*400+396 = 119996
      exp_q.push_back(wr(32'd119996, 4'b1111, 8'hE7));
      run_cmd("overhang", 10'd396, 10'd299, 10'd10, 10'd4, 8'hE7, 3, 1'b0);
      run_cmd("x_outside", 10'd400, 10'd0, 10'd4, 10'd1, 8'h01, 2, 1'b0);
`else
      run_cmd("overhang", 10'd396, 10'd299, 10'd10, 10'd4, 8'hE7, 2, 1'b1);
      run_cmd("x_outside", 10'd400, 10'd0, 10'd4, 10'd1, 8'h01, 2, 1'b1);
`endif

      // Reset during the third write of a 40x10 fill
      drive_cmd(10'd0, 10'd0, 10'd40, 10'd10, 8'h77);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("abort write0", {bram_addr, bram_we, bram_din}, wr(32'd0, 4'b1111, 8'h77));
      @(negedge clk);
      check("abort write1", {bram_addr, bram_we, bram_din}, wr(32'd4, 4'b1111, 8'h77));
      @(negedge clk);
      check("abort write2", {bram_addr, bram_we, bram_din}, wr(32'd8, 4'b1111, 8'h77));
      reset_ni = 1'b0;
      @(negedge clk);
      check("abort ready", W'(cmd_ready), W'(1));
      check("abort busy", W'(busy), W'(0));
      check("abort outputs", {done, err, bram_en, bram_we, bram_addr, bram_din}, W'(0));
      reset_ni = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("abort quiet", {bram_en, done}, W'(0));
      end

      // Back-to-back with valid held and fields changing while busy
      drive_cmd(10'd0, 10'd10, 10'd4, 10'd1, 8'h11);
      @(negedge clk);
      drive_cmd(10'd8, 10'd20, 10'd2, 10'd1, 8'h22);
      check("b2b c1 ready", W'(cmd_ready), W'(0));
      @(negedge clk);
      check("b2b c2 ready", W'(cmd_ready), W'(0));
      check("b2b first write", {bram_en, bram_addr, bram_we, bram_din}, {1'b1, wr(32'd4000, 4'b1111, 8'h11)});
      @(negedge clk);
      check("b2b c3 done", {cmd_ready, done, err}, W'(3'b010));
      @(negedge clk);
      check("b2b c4 ready", {cmd_ready, busy}, W'(2'b10));
      @(negedge clk);
      cmd_valid = 1'b0;
      scramble_cmd();
      check("b2b c5 setup", {cmd_ready, busy, bram_en}, W'(3'b010));
      @(negedge clk);
      check("b2b second write", {bram_en, bram_addr, bram_we, bram_din}, {1'b1, wr(32'd8008, 4'b0011, 8'h22)});
      @(negedge clk);
      check("b2b c7 done", {done, err, bram_en}, W'(3'b100));
      @(negedge clk);
      check("b2b c8 idle", {cmd_ready, busy, done}, W'(3'b100));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
